// File: rtl/wb_result_sequencer.sv
// Writeback sequencer: latches one execute result bundle and drains its live results in order
// onto the register, segment or handshaked memory write port, then pulses retire with the bundle EIP.
module wb_result_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        stall,
  input  logic [31:0] EIP_in,
  input  logic [63:0] res1,
  input  logic [63:0] res2,
  input  logic [63:0] res3,
  input  logic [63:0] res4,
  input  logic        res1_wb,
  input  logic        res2_wb,
  input  logic        res3_wb,
  input  logic        res4_wb,
  input  logic        res1_is_reg,
  input  logic        res2_is_reg,
  input  logic        res3_is_reg,
  input  logic        res4_is_reg,
  input  logic        res1_is_seg,
  input  logic        res2_is_seg,
  input  logic        res3_is_seg,
  input  logic        res4_is_seg,
  input  logic        res1_is_mem,
  input  logic        res2_is_mem,
  input  logic        res3_is_mem,
  input  logic        res4_is_mem,
  input  logic [31:0] res1_dest,
  input  logic [31:0] res2_dest,
  input  logic [31:0] res3_dest,
  input  logic [31:0] res4_dest,
  input  logic [1:0]  ressize,
  output logic        reg_wr_en,
  output logic [2:0]  reg_wr_addr,
  output logic [63:0] reg_wr_data,
  output logic [1:0]  reg_wr_size,
  output logic        seg_wr_en,
  output logic [2:0]  seg_wr_addr,
  output logic [15:0] seg_wr_data,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [63:0] mem_wr_data,
  output logic [1:0]  mem_wr_size,
  output logic        retire,
  output logic [31:0] retire_EIP,
  output logic        wb_err
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT) - 32'd1;

  state_t      state_r, state_s;
  logic [3:0]  mask_r, mask_s, new_mask_s;
  logic [3:0]  mem_r, seg_r;
  logic [63:0] res_r [4];
  logic [31:0] dest_r [4];
  logic [1:0]  size_r;
  logic [31:0] eip_r;
  logic [31:0] tmo_cnt_r, tmo_cnt_s;
  logic [1:0]  sel_s;
  logic [3:0]  sel_oh_s;
  logic        busy_s, mem_sel_s, done_s, drop_s, last_s, accept_s;
  logic [63:0] res_in_s [4];
  logic [31:0] dest_in_s [4];
  logic [3:0]  wb_in_s, reg_in_s, seg_in_s, mem_in_s;

  assign res_in_s  = '{res1, res2, res3, res4};
  assign dest_in_s = '{res1_dest, res2_dest, res3_dest, res4_dest};
  assign wb_in_s   = {res4_wb, res3_wb, res2_wb, res1_wb};
  assign reg_in_s  = {res4_is_reg, res3_is_reg, res2_is_reg, res1_is_reg};
  assign seg_in_s  = {res4_is_seg, res3_is_seg, res2_is_seg, res1_is_seg};
  assign mem_in_s  = {res4_is_mem, res3_is_mem, res2_is_mem, res1_is_mem};
  assign new_mask_s = wb_in_s & (reg_in_s | seg_in_s | mem_in_s);

  // State register and latched bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mask_r    <= 4'd0;
      tmo_cnt_r <= 32'd0;
      mem_r     <= 4'd0;
      seg_r     <= 4'd0;
      size_r    <= 2'd0;
      eip_r     <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        res_r[i]  <= 64'd0;
        dest_r[i] <= 32'd0;
      end
    end else begin
      state_r   <= state_s;
      mask_r    <= mask_s;
      tmo_cnt_r <= tmo_cnt_s;
      if (accept_s) begin
        mem_r  <= mem_in_s;
        seg_r  <= seg_in_s;
        size_r <= ressize;
        eip_r  <= EIP_in;
        for (int i = 0; i < 4; i++) begin
          res_r[i]  <= res_in_s[i];
          dest_r[i] <= dest_in_s[i];
        end
      end else begin
        mem_r  <= mem_r;
        seg_r  <= seg_r;
        size_r <= size_r;
        eip_r  <= eip_r;
      end
    end
  end

  // Next-state: pick lowest pending result, decide completion, back-pressure and timeout
  always_comb begin
    casez (mask_r)
      4'b???1: sel_s = 2'd0;
      4'b??10: sel_s = 2'd1;
      4'b?100: sel_s = 2'd2;
      4'b1000: sel_s = 2'd3;
      default: sel_s = 2'd0;
    endcase
    sel_oh_s  = 4'b0001 << sel_s;
    busy_s    = (state_r == DRAIN) && (mask_r != 4'd0);
    mem_sel_s = busy_s && mem_r[sel_s];
    drop_s    = 1'b0;
    done_s    = 1'b0;
    if (mem_sel_s) begin
      drop_s = (MEM_TIMEOUT != 0) && !mem_wr_ready && (tmo_cnt_r == TMO_LAST);
      done_s = mem_wr_ready || drop_s;
    end else begin
      done_s = busy_s;
    end
    last_s   = (state_r == DRAIN) &&
               ((mask_r == 4'd0) || (done_s && ((mask_r & ~sel_oh_s) == 4'd0)));
    stall    = (state_r == DRAIN) && !last_s;
    accept_s = valid_in && !stall;
    if (accept_s) begin
      mask_s = new_mask_s;
    end else if (done_s) begin
      mask_s = mask_r & ~sel_oh_s;
    end else begin
      mask_s = mask_r;
    end
    if (mem_sel_s && !done_s) begin
      tmo_cnt_s = tmo_cnt_r + 32'd1;
    end else begin
      tmo_cnt_s = 32'd0;
    end
    case (state_r)
      IDLE:    state_s = accept_s ? DRAIN : IDLE;
      DRAIN:   state_s = (accept_s || !last_s) ? DRAIN : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode: one write per cycle with priority mem > seg > reg
  always_comb begin
    reg_wr_en    = 1'b0;
    reg_wr_addr  = 3'd0;
    reg_wr_data  = 64'd0;
    reg_wr_size  = 2'd0;
    seg_wr_en    = 1'b0;
    seg_wr_addr  = 3'd0;
    seg_wr_data  = 16'd0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = 32'd0;
    mem_wr_data  = 64'd0;
    mem_wr_size  = 2'd0;
    wb_err       = drop_s;
    retire       = last_s;
    retire_EIP   = last_s ? eip_r : 32'd0;
    if (mem_sel_s) begin
      mem_wr_valid = 1'b1;
      mem_wr_addr  = dest_r[sel_s];
      mem_wr_data  = res_r[sel_s];
      mem_wr_size  = size_r;
    end else if (busy_s && seg_r[sel_s]) begin
      seg_wr_en   = 1'b1;
      seg_wr_addr = dest_r[sel_s][2:0];
      seg_wr_data = res_r[sel_s][15:0];
    end else if (busy_s) begin
      reg_wr_en   = 1'b1;
      reg_wr_addr = dest_r[sel_s][2:0];
      reg_wr_data = res_r[sel_s];
      reg_wr_size = size_r;
    end else begin
      reg_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_result_sequencer.sv
// Bench for wb_result_sequencer: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a queue-of-writes model of the bundle drain.
module tb_wb_result_sequencer;
  localparam int TO = 4;
  localparam logic [1:0] K_REG = 2'd0, K_SEG = 2'd1, K_MEM = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid_in, stall, mem_wr_ready;
  logic [31:0] EIP_in;
  logic [1:0]  ressize;
  logic [63:0] res_a [4];
  logic [31:0] dest_a [4];
  logic [3:0]  wb_a, reg_a, seg_a, mem_a;
  logic        reg_wr_en, seg_wr_en, mem_wr_valid, retire, wb_err;
  logic [2:0]  reg_wr_addr, seg_wr_addr;
  logic [63:0] reg_wr_data, mem_wr_data;
  logic [1:0]  reg_wr_size, mem_wr_size;
  logic [15:0] seg_wr_data;
  logic [31:0] mem_wr_addr, retire_EIP;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  wb_result_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .EIP_in(EIP_in),
    .res1(res_a[0]), .res2(res_a[1]), .res3(res_a[2]), .res4(res_a[3]),
    .res1_wb(wb_a[0]), .res2_wb(wb_a[1]), .res3_wb(wb_a[2]), .res4_wb(wb_a[3]),
    .res1_is_reg(reg_a[0]), .res2_is_reg(reg_a[1]), .res3_is_reg(reg_a[2]), .res4_is_reg(reg_a[3]),
    .res1_is_seg(seg_a[0]), .res2_is_seg(seg_a[1]), .res3_is_seg(seg_a[2]), .res4_is_seg(seg_a[3]),
    .res1_is_mem(mem_a[0]), .res2_is_mem(mem_a[1]), .res3_is_mem(mem_a[2]), .res4_is_mem(mem_a[3]),
    .res1_dest(dest_a[0]), .res2_dest(dest_a[1]), .res3_dest(dest_a[2]), .res4_dest(dest_a[3]),
    .ressize(ressize),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_size(reg_wr_size),
    .seg_wr_en(seg_wr_en), .seg_wr_addr(seg_wr_addr), .seg_wr_data(seg_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_size(mem_wr_size),
    .retire(retire), .retire_EIP(retire_EIP), .wb_err(wb_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a bundle is a queue of pending writes drained head-first
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         m_q[$];
  wr_t         h;
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_eip = 32'd0;
  logic [1:0]  m_size = 2'd0;
  logic        e_reg, e_seg, e_mem, e_err, e_ret, e_stall, done, last, accept;
  logic [2:0]  e_ra, e_sa;
  logic [63:0] e_rd, e_md;
  logic [15:0] e_sd;
  logic [1:0]  e_rs, e_ms;
  logic [31:0] e_ma, e_eip;

  always @(negedge clk) begin
    if (model_on) begin
      {e_reg, e_seg, e_mem, e_err, done, last} = 6'd0;
      e_ra = 3'd0; e_sa = 3'd0; e_rd = 64'd0; e_md = 64'd0; e_sd = 16'd0;
      e_rs = 2'd0; e_ms = 2'd0; e_ma = 32'd0;
      if (m_busy) begin
        if (m_q.size() == 0) begin
          last = 1'b1;
        end else begin
          h = m_q[0];
          case (h.kind)
            K_REG: begin e_reg = 1'b1; e_ra = h.addr[2:0]; e_rd = h.data; e_rs = m_size; done = 1'b1; end
            K_SEG: begin e_seg = 1'b1; e_sa = h.addr[2:0]; e_sd = h.data[15:0]; done = 1'b1; end
            default: begin
              e_mem = 1'b1; e_ma = h.addr; e_md = h.data; e_ms = m_size;
              e_err = !mem_wr_ready && (m_wait + 1 == TO);
              done  = mem_wr_ready || e_err;
            end
          endcase
          last = done && (m_q.size() == 1);
        end
      end
      e_stall = m_busy && !last;
      e_ret   = last;
      e_eip   = last ? m_eip : 32'd0;
      chk("stall", stall, e_stall);
      chk("retire", retire, e_ret);
      chk("retire_EIP", retire_EIP, e_eip);
      chk("wb_err", wb_err, e_err);
      chk("reg_wr_en", reg_wr_en, e_reg);
      chk("reg_wr_addr", reg_wr_addr, e_ra);
      chk("reg_wr_data", reg_wr_data, e_rd);
      chk("reg_wr_size", reg_wr_size, e_rs);
      chk("seg_wr_en", seg_wr_en, e_seg);
      chk("seg_wr_addr", seg_wr_addr, e_sa);
      chk("seg_wr_data", seg_wr_data, e_sd);
      chk("mem_wr_valid", mem_wr_valid, e_mem);
      chk("mem_wr_addr", mem_wr_addr, e_ma);
      chk("mem_wr_data", mem_wr_data, e_md);
      chk("mem_wr_size", mem_wr_size, e_ms);
      accept = valid_in && !e_stall;
      if (rst) begin
        m_q.delete();
        m_busy = 1'b0;
        m_wait = 0;
      end else begin
        if (m_busy && m_q.size() > 0) begin
          if (done) begin
            void'(m_q.pop_front());
            m_wait = 0;
          end else begin
            m_wait++;
          end
        end
        if (last) m_busy = 1'b0;
        if (accept) begin
          m_busy = 1'b1;
          m_eip  = EIP_in;
          m_size = ressize;
          m_q.delete();
          for (int i = 0; i < 4; i++) begin
            if (wb_a[i] && (mem_a[i] || seg_a[i] || reg_a[i])) begin
              h.kind = mem_a[i] ? K_MEM : (seg_a[i] ? K_SEG : K_REG);
              h.addr = dest_a[i];
              h.data = res_a[i];
              m_q.push_back(h);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wb_a = 4'd0; reg_a = 4'd0; seg_a = 4'd0; mem_a = 4'd0;
    for (int i = 0; i < 4; i++) begin
      res_a[i]  = 64'd0;
      dest_a[i] = 32'd0;
    end
  endtask

  // kind bits: {mem, seg, reg}
  task automatic set_res(input int i, input logic [2:0] kind, input logic [31:0] dest, input logic [63:0] data);
    wb_a[i] = 1'b1;
    {mem_a[i], seg_a[i], reg_a[i]} = kind;
    dest_a[i] = dest;
    res_a[i]  = data;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; mem_wr_ready = 1'b0; EIP_in = 32'd0; ressize = 2'd0;
    clr();
    tick(); tick();
    rst = 1'b0;
    model_on = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_stall", stall, 64'd0);
      chk("idle_strobes", {reg_wr_en, seg_wr_en, mem_wr_valid, retire, wb_err}, 64'd0);
      tick();
    end

    // reg then seg
    set_res(0, 3'b001, 32'd3, 64'h1234);
    set_res(1, 3'b010, 32'd2, 64'h0018);
    ressize = 2'b10; EIP_in = 32'hCAFE0000; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; clr();
    @(negedge clk);
    chk("t2_reg_en", reg_wr_en, 64'd1);
    chk("t2_reg_addr", reg_wr_addr, 64'd3);
    chk("t2_reg_data", reg_wr_data, 64'h1234);
    chk("t2_reg_size", reg_wr_size, 64'd2);
    chk("t2_stall1", stall, 64'd1);
    chk("t2_noretire", retire, 64'd0);
    tick();
    @(negedge clk);
    chk("t2_seg_en", seg_wr_en, 64'd1);
    chk("t2_seg_addr", seg_wr_addr, 64'd2);
    chk("t2_seg_data", seg_wr_data, 64'h0018);
    chk("t2_retire", retire, 64'd1);
    chk("t2_retire_eip", retire_EIP, 64'hCAFE0000);
    chk("t2_stall2", stall, 64'd0);
    tick();

    // mem with 3 wait cycles
    set_res(2, 3'b100, 32'h1000, 64'hAABBCCDD);
    ressize = 2'b11; EIP_in = 32'h100; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; clr();
    for (int k = 0; k < 4; k++) begin
      mem_wr_ready = (k == 3);
      @(negedge clk);
      chk("t3_mem_valid", mem_wr_valid, 64'd1);
      chk("t3_mem_addr", mem_wr_addr, 64'h1000);
      chk("t3_mem_data", mem_wr_data, 64'hAABBCCDD);
      chk("t3_retire", retire, (k == 3) ? 64'd1 : 64'd0);
      tick();
    end
    mem_wr_ready = 1'b0;
    @(negedge clk);
    chk("t3_mem_released", mem_wr_valid, 64'd0);
    tick();

    // empty bundle, back-to-back accept
    EIP_in = 32'h200; valid_in = 1'b1;
    tick();
    set_res(0, 3'b001, 32'd5, 64'h77); EIP_in = 32'h204;
    @(negedge clk);
    chk("t4_empty_retire", retire, 64'd1);
    chk("t4_empty_eip", retire_EIP, 64'h200);
    chk("t4_no_stall", stall, 64'd0);
    chk("t4_no_strobe", reg_wr_en, 64'd0);
    tick();
    valid_in = 1'b0; clr();
    @(negedge clk);
    chk("t4_b2b_reg", reg_wr_en, 64'd1);
    chk("t4_b2b_addr", reg_wr_addr, 64'd5);
    chk("t4_b2b_retire", retire, 64'd1);
    tick();

    // timeout then following reg write
    set_res(0, 3'b100, 32'h2000, 64'h55);
    set_res(3, 3'b001, 32'd7, 64'h99);
    EIP_in = 32'h300; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; clr();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t5_wb_err", wb_err, (k == 4) ? 64'd1 : 64'd0);
      chk("t5_mem_valid", mem_wr_valid, 64'd1);
      tick();
    end
    @(negedge clk);
    chk("t5_next_reg", reg_wr_en, 64'd1);
    chk("t5_next_addr", reg_wr_addr, 64'd7);
    chk("t5_retire", retire, 64'd1);
    chk("t5_err_clear", wb_err, 64'd0);
    tick();

    // reset during memory request
    set_res(0, 3'b100, 32'h3000, 64'h66);
    EIP_in = 32'h400; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; clr(); rst = 1'b1;
    @(negedge clk);
    chk("t6_mem_inflight", mem_wr_valid, 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_outputs_zero", {mem_wr_valid, reg_wr_en, seg_wr_en, retire, wb_err, stall}, 64'd0);
    set_res(0, 3'b001, 32'd1, 64'h11); EIP_in = 32'h500;
    tick();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0; clr();
    @(negedge clk);
    chk("t6_new_bundle", reg_wr_en, 64'd1);
    chk("t6_new_addr", reg_wr_addr, 64'd1);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        res_a[i]  = {$urandom, $urandom};
        dest_a[i] = $urandom;
        wb_a[i]   = ($urandom_range(0, 3) != 0);
        reg_a[i]  = $urandom_range(0, 1) != 0;
        seg_a[i]  = $urandom_range(0, 2) == 0;
        mem_a[i]  = $urandom_range(0, 2) == 0;
      end
      ressize      = 2'($urandom_range(0, 3));
      EIP_in       = $urandom;
      valid_in     = $urandom_range(0, 1) != 0;
      mem_wr_ready = $urandom_range(0, 1) != 0;
      rst          = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 1'b0; valid_in = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
